joy_ent_select: RTL

// Upstream feeder of the VGA draw stage: turns the 5 raw active-low joystick lines into a
// 2-bit entertainment code (ent_code) for the renderer. Each line is synchronised and

---
 rtl/joy_ent_select.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/joy_ent_select.sv
// Joystick front end for the VGA draw stage: sync, debounce, press
// detect and a two-state menu that hands a frame-aligned ent_code downstream.
module joy_ent_select #(
  parameter int          DEBOUNCE_CYC = 500_000,
  parameter int          NUM_ENT      = 3,
  parameter logic [1:0]  MENU_CODE    = 2'b11
) (
  input  logic       sys_clk,
  input  logic       sys_reset,
  input  logic [4:0] joy_n,
  input  logic       VGA_VS,
  output logic [1:0] ent_code,
  output logic [1:0] sel_code,
  output logic       running,
  output logic [4:0] joy_evt
);

  localparam int             CW      = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0]  CNT_TOP = CW'(DEBOUNCE_CYC - 1);
  localparam logic [1:0]     LAST    = 2'(NUM_ENT - 1);

  typedef enum logic {
    S_BROWSE,
    S_RUN
  } state_t;

  logic [4:0]    r_joy_s1;
  logic [4:0]    r_joy_s2;
  logic          r_vs_s1;
  logic          r_vs_s2;
  logic          r_vs_d;
  logic [4:0]    r_stable;
  logic [4:0]    r_stable_d;
  logic [CW-1:0] r_cnt [5];
  logic [4:0]    r_evt;

  state_t        r_state;
  logic [1:0]    r_sel;
  logic          r_pend;
  logic [1:0]    r_tgt;
  logic [1:0]    r_ent;

  state_t        w_state_nxt;
  logic [1:0]    w_sel_nxt;
  logic          w_pend_nxt;
  logic [1:0]    w_tgt_nxt;
  logic [1:0]    w_ent_nxt;
  logic          w_frame_start;
  logic          w_fire;
  logic          w_dec;
  logic          w_inc;

  // Two-flop synchronisers for the buttons and vertical sync.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      r_joy_s1 <= '1;
      r_joy_s2 <= '1;
      r_vs_s1  <= 1'b1;
      r_vs_s2  <= 1'b1;
      r_vs_d   <= 1'b1;
    end else begin
      r_joy_s1 <= joy_n;
      r_joy_s2 <= r_joy_s1;
      r_vs_s1  <= VGA_VS;
      r_vs_s2  <= r_vs_s1;
      r_vs_d   <= r_vs_s2;
    end
  end

  assign w_frame_start = r_vs_d & ~r_vs_s2;

  // Per-line debounce: a change must persist DEBOUNCE_CYC cycles.
  always_ff @(posedge sys_clk) begin
    for (int i = 0; i < 5; i++) begin
      if (sys_reset) begin
        r_cnt[i]    <= '0;
        r_stable[i] <= 1'b1;
      end else if (r_joy_s2[i] == r_stable[i]) begin
        r_cnt[i]    <= '0;
      end else if (r_cnt[i] == CNT_TOP) begin
        r_cnt[i]    <= '0;
        r_stable[i] <= r_joy_s2[i];
      end else begin
        r_cnt[i]    <= r_cnt[i] + CW'(1);
      end
    end
  end

  // Press pulse on the cycle after a debounced 1->0 transition.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      r_stable_d <= '1;
      r_evt      <= '0;
    end else begin
      r_stable_d <= r_stable;
      r_evt      <= r_stable_d & ~r_stable;
    end
  end

  assign w_fire = r_evt[4];
  assign w_dec  = r_evt[0] | r_evt[2];
  assign w_inc  = r_evt[1] | r_evt[3];

  // Menu next-state; fire beats moves, and beats a same-cycle commit.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_pend_nxt  = r_pend;
    w_tgt_nxt   = r_tgt;
    w_ent_nxt   = r_ent;
    unique case (r_state)
      S_BROWSE: begin
        if (w_fire) begin
          w_state_nxt = S_RUN;
          w_pend_nxt  = 1'b1;
          w_tgt_nxt   = r_sel;
        end else if (w_dec && !w_inc) begin
          w_sel_nxt = (r_sel == 2'd0) ? LAST : r_sel - 2'd1;
        end else if (w_inc && !w_dec) begin
          w_sel_nxt = (r_sel == LAST) ? 2'd0 : r_sel + 2'd1;
        end
      end
      S_RUN: begin
        if (w_fire) begin
          w_state_nxt = S_BROWSE;
          w_pend_nxt  = 1'b1;
          w_tgt_nxt   = MENU_CODE;
        end
      end
      default: w_state_nxt = S_BROWSE;
    endcase
    if (!w_fire && w_frame_start && r_pend) begin
      w_ent_nxt  = r_tgt;
      w_pend_nxt = 1'b0;
    end
  end

  // Menu state register.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      r_state <= S_BROWSE;
      r_sel   <= 2'd0;
      r_pend  <= 1'b0;
      r_tgt   <= MENU_CODE;
      r_ent   <= MENU_CODE;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_pend  <= w_pend_nxt;
      r_tgt   <= w_tgt_nxt;
      r_ent   <= w_ent_nxt;
    end
  end

  assign ent_code = r_ent;
  assign sel_code = r_sel;
  assign running  = (r_state == S_RUN);
  assign joy_evt  = r_evt;

endmodule
